// File: rtl/move_entry_if.sv
// move_entry_if: pushbutton/switch inputs, board feedback and move outputs between
// the front panel, move_entry and the game FSM.
interface move_entry_if;
  logic       rawEnter_L;
  logic       rawNewGame_L;
  logic [3:0] sw;
  logic [3:0] h3, h2, h1, h0, c3, c2, c1, c0;
  logic [3:0] hMove;
  logic       enter_L;
  logic       newGame_L;
  logic       badMove;
  modport master (output rawEnter_L, rawNewGame_L, sw, h3, h2, h1, h0, c3, c2, c1, c0,
                  input hMove, enter_L, newGame_L, badMove);
  modport slave  (input rawEnter_L, rawNewGame_L, sw, h3, h2, h1, h0, c3, c2, c1, c0,
                  output hMove, enter_L, newGame_L, badMove);
endinterface

// File: rtl/move_entry.sv
// move_entry: synchronizes, debounces and validates a human move, issuing a one-cycle enter_L strobe.
// Define MOVE_ENTRY_DEBOUNCE_EN to enable DEBOUNCE_CYCLES press/release filtering.
module move_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic         clock,
  input logic         reset,
  move_entry_if.slave bus
);
`ifdef MOVE_ENTRY_DEBOUNCE_EN
  localparam logic [7:0] LP_N = 8'(DEBOUNCE_CYCLES);
`else
  localparam logic [7:0] LP_N = (DEBOUNCE_CYCLES > 0) ? 8'd1 : 8'd1;
`endif
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PULSE, RELEASE} state_t;
  state_t     r_state, w_state;
  logic [1:0] r_ent_s, r_ng_s;
  logic [3:0] r_sw_s1, r_sw_s2;
  logic [7:0] r_cnt, w_cnt;
  logic [3:0] r_hmove, w_hmove;
  logic       r_enter_l, w_enter_l, r_bad, w_bad;
  logic       w_ent, w_ng, w_dup, w_valid, w_eval;
  logic [3:0] w_sw;
  assign w_ent = r_ent_s[1];
  assign w_ng  = r_ng_s[1];
  assign w_sw  = r_sw_s2;
  // empty slots are 0 and a legal move is nonzero, so a plain compare suffices
  assign w_dup = (w_sw == bus.h3) | (w_sw == bus.h2) | (w_sw == bus.h1) | (w_sw == bus.h0) |
                 (w_sw == bus.c3) | (w_sw == bus.c2) | (w_sw == bus.c1) | (w_sw == bus.c0);
  assign w_valid = (w_sw != 4'd0) && (w_sw <= 4'd9) && !w_dup;
  assign bus.hMove     = r_hmove;
  assign bus.enter_L   = r_enter_l;
  assign bus.newGame_L = w_ng;
  assign bus.badMove   = r_bad;
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_hmove   = r_hmove;
    w_enter_l = 1'b1;
    w_bad     = r_bad;
    w_eval    = 1'b0;
    if (!w_ng) begin
      w_state = RELEASE;
      w_cnt   = 8'd0;
      w_bad   = 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (!w_ent) begin
`ifdef MOVE_ENTRY_DEBOUNCE_EN
            w_state = DEBOUNCE;
            w_cnt   = 8'd1;
`else
            w_eval  = 1'b1;
`endif
          end
        DEBOUNCE:
          if (w_ent) begin
            w_state = IDLE;
            w_cnt   = 8'd0;
          end else if (r_cnt >= LP_N)
            w_eval = 1'b1;
          else
            w_cnt = r_cnt + 8'd1;
        PULSE: begin
          w_state = RELEASE;
          w_cnt   = 8'd0;
        end
        RELEASE:
          if (!w_ent)
            w_cnt = 8'd0;
          else if (r_cnt + 8'd1 >= LP_N) begin
            w_state = IDLE;
            w_cnt   = 8'd0;
          end else
            w_cnt = r_cnt + 8'd1;
      endcase
    end
    if (w_eval) begin
      w_cnt     = 8'd0;
      w_state   = w_valid ? PULSE : RELEASE;
      w_hmove   = w_valid ? w_sw : r_hmove;
      w_enter_l = !w_valid;
      w_bad     = !w_valid;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ent_s   <= 2'b11;
      r_ng_s    <= 2'b11;
      r_sw_s1   <= 4'd0;
      r_sw_s2   <= 4'd0;
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_hmove   <= 4'd0;
      r_enter_l <= 1'b1;
      r_bad     <= 1'b0;
    end else begin
      r_ent_s   <= {r_ent_s[0], bus.rawEnter_L};
      r_ng_s    <= {r_ng_s[0], bus.rawNewGame_L};
      r_sw_s1   <= bus.sw;
      r_sw_s2   <= r_sw_s1;
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_hmove   <= w_hmove;
      r_enter_l <= w_enter_l;
      r_bad     <= w_bad;
    end
  end
endmodule

// File: tb/tb_move_entry.sv
// tb_move_entry: directed table of presses plus new-game, glitch and mid-press reset sequences.
module tb_move_entry;
`ifdef MOVE_ENTRY_DEBOUNCE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int D   = 4;
  localparam int LAT = EN ? D + 3 : 3;
  localparam int OFF = EN ? 2 : 0;
  typedef struct {
    logic [3:0] sw;
    logic [3:0] h0;
    logic [3:0] c2;
    int         n;
    int         hm;
    int         bad;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;
  move_entry_if bus();
  move_entry #(.DEBOUNCE_CYCLES(D)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic press(input int hold, output int n, output int first);
    n = 0;
    first = 0;
    bus.rawEnter_L = 1'b0;
    for (int e = 1; e <= hold; e++) begin
      step();
      if (!bus.enter_L) begin
        n++;
        if (first == 0) first = e;
      end
    end
    bus.rawEnter_L = 1'b1;
    repeat (12) begin
      step();
      if (!bus.enter_L) n++;
    end
  endtask
  initial begin
    vec_t tbl[11];
    int n, first;
    tbl[0]  = '{4'd5,  4'd0, 4'd0, 1, 5, 0};
    tbl[1]  = '{4'd6,  4'd6, 4'd0, 0, 5, 1};
    tbl[2]  = '{4'd9,  4'd6, 4'd0, 1, 9, 0};
    tbl[3]  = '{4'd0,  4'd6, 4'd0, 0, 9, 1};
    tbl[4]  = '{4'd12, 4'd6, 4'd0, 0, 9, 1};
    tbl[5]  = '{4'd4,  4'd6, 4'd0, 1, 4, 0};
    tbl[6]  = '{4'd3,  4'd6, 4'd3, 0, 4, 1};
    tbl[7]  = '{4'd10, 4'd6, 4'd3, 0, 4, 1};
    tbl[8]  = '{4'd1,  4'd6, 4'd3, 1, 1, 0};
    tbl[9]  = '{4'd15, 4'd6, 4'd3, 0, 1, 1};
    tbl[10] = '{4'd9,  4'd9, 4'd3, 0, 1, 1};
    bus.rawEnter_L = 1'b1;
    bus.rawNewGame_L = 1'b1;
    bus.sw = 4'd0;
    {bus.h3, bus.h2, bus.h1, bus.h0, bus.c3, bus.c2, bus.c1, bus.c0} = '0;
    repeat (3) step();
    chk("rst_hMove", bus.hMove, 0);
    chk("rst_enter_L", bus.enter_L, 1);
    chk("rst_newGame_L", bus.newGame_L, 1);
    chk("rst_badMove", bus.badMove, 0);
    reset = 1'b0;
    step();
    chk("post_rst_enter_L", bus.enter_L, 1);
    for (int i = 0; i < 11; i++) begin
      bus.sw = tbl[i].sw;
      bus.h0 = tbl[i].h0;
      bus.c2 = tbl[i].c2;
      press(20, n, first);
      chk($sformatf("vec%0d_strobes", i), n, tbl[i].n);
      if (tbl[i].n == 1) chk($sformatf("vec%0d_latency", i), first, LAT);
      chk($sformatf("vec%0d_hMove", i), bus.hMove, tbl[i].hm);
      chk($sformatf("vec%0d_badMove", i), bus.badMove, tbl[i].bad);
    end
    // new game asserted while the press is being debounced
    bus.sw = 4'd7;
    bus.h0 = 4'd0;
    bus.c2 = 4'd0;
    bus.rawEnter_L = 1'b0;
    n = 0;
    for (int e = 1; e <= 24; e++) begin
      if (e - 1 == OFF) bus.rawNewGame_L = 1'b0;
      if (e == 12) bus.rawNewGame_L = 1'b1;
      step();
      if (e == OFF + 1) chk("ng_sync_still_high", bus.newGame_L, 1);
      if (e == OFF + 2) chk("ng_sync_low", bus.newGame_L, 0);
      if (!bus.enter_L) n++;
    end
    chk("ng_no_strobe", n, 0);
    chk("ng_badMove", bus.badMove, 0);
    chk("ng_hMove_held", bus.hMove, 1);
    chk("ng_released", bus.newGame_L, 1);
    bus.rawEnter_L = 1'b1;
    repeat (8) step();
    press(20, n, first);
    chk("ng_repress_strobes", n, 1);
    chk("ng_repress_latency", first, LAT);
    chk("ng_repress_hMove", bus.hMove, 7);
    // two-cycle glitch: filtered only when debounce is enabled
    bus.sw = 4'd2;
    press(2, n, first);
    chk("glitch_strobes", n, EN ? 0 : 1);
    chk("glitch_hMove", bus.hMove, EN ? 7 : 2);
    // reset one edge before the strobe would fire, button still held afterwards
    bus.sw = 4'd8;
    bus.rawEnter_L = 1'b0;
    n = 0;
    for (int e = 1; e < LAT; e++) begin
      step();
      if (!bus.enter_L) n++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_pre_strobes", n, 0);
    chk("midrst_enter_L", bus.enter_L, 1);
    chk("midrst_hMove", bus.hMove, 0);
    press(20, n, first);
    chk("midrst_repress_strobes", n, 1);
    chk("midrst_repress_latency", first, LAT);
    chk("midrst_repress_hMove", bus.hMove, 8);
    chk("midrst_badMove", bus.badMove, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a press or release (legal 1..255).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rawEnter_L  input  1  asynchronous pushbutton, active low.
REQ-005 SHALL have port: rawNewGame_L  input  1  asynchronous pushbutton, active low.
REQ-006 SHALL have port: sw  input  4  asynchronous switch value for the human move.
REQ-007 SHALL have port: h3, h2, h1, h0, c3, c2, c1, c0  input  4 each  feedback from the game FSM (0 = empty slot).
REQ-008 SHALL have port: hMove  output  4  registered, accepted human move to the game FSM.
REQ-009 SHALL have port: enter_L  output  1  registered, active-low one-cycle move strobe to the game FSM.
REQ-010 SHALL have port: newGame_L  output  1  synchronized rawNewGame_L to the game FSM.
REQ-011 SHALL have port: badMove  output  1  registered; high = last press rejected.

Function
REQ-012 SHALL pass rawEnter_L, rawNewGame_L and sw each through a 2-flop synchronizer before any use.
REQ-013 SHALL implement FSM states IDLE, DEBOUNCE, PULSE, RELEASE.
REQ-014 IDLE: sync enter low -> DEBOUNCE with count=1; else stay.
REQ-015 DEBOUNCE: sync enter high -> IDLE (bounce, no effect); count reaches DEBOUNCE_CYCLES -> evaluate move, go PULSE if valid, RELEASE if invalid.
REQ-016 Move SHALL be valid iff synchronized sw is in 1..9 and differs from every nonzero value among h3..h0, c3..c0 sampled in the evaluating cycle.
REQ-017 Valid: hMove loads synchronized sw and enter_L goes low in the same edge; badMove clears.
REQ-018 PULSE: enter_L low for exactly one clock cycle, then -> RELEASE; hMove held constant throughout and afterwards until the next valid acceptance.
REQ-019 Invalid: hMove and enter_L unchanged, badMove set high, no strobe.
REQ-020 RELEASE: -> IDLE only after sync enter high for DEBOUNCE_CYCLES consecutive cycles; any low sample restarts the count; a held button never produces a second strobe.
REQ-021 Latency: with button held low, enter_L SHALL be low during the cycle after edge DEBOUNCE_CYCLES+3, counting edge 1 as the first edge sampling rawEnter_L low.
REQ-022 newGame_L SHALL equal rawNewGame_L delayed by the 2 synchronizer flops, with no debounce.
REQ-023 newGame_L low SHALL have priority: FSM -> RELEASE, enter_L forced high, badMove cleared, hMove held; any press in progress is aborted without a strobe.
REQ-024 Duplicate moves, 0, and 10..15 SHALL all be rejected per REQ-019.

Reset
REQ-025 On reset: state IDLE, counter 0, synchronizer flops 1 for button inputs and 0 for sw, hMove=0, enter_L=1, newGame_L=1, badMove=0.
REQ-026 Reset asserted mid-DEBOUNCE or mid-PULSE SHALL abort with no strobe; a button still held after reset SHALL be treated as a new press.

Configuration
REQ-027 Macro MOVE_ENTRY_DEBOUNCE_EN defined: behaviour exactly as REQ-014..REQ-021.
REQ-028 Macro MOVE_ENTRY_DEBOUNCE_EN undefined: DEBOUNCE_CYCLES is ignored and treated as 1; IDLE evaluates on the first sync low sample (enter_L low after edge 3); RELEASE exits on the first sync high sample.

Verification (DEBOUNCE_CYCLES=4, debounce enabled unless noted)
REQ-029 Reset, sw=5, rawEnter_L held low from edge 1 -> enter_L low for exactly the cycle after edge 7, hMove=5, badMove=0, no further strobe while held.
REQ-030 rawEnter_L glitches low 2 cycles, then high -> no strobe, hMove unchanged.
REQ-031 h0=6, sw=6, press -> no strobe, badMove=1, hMove unchanged; then sw=9, press -> strobe, hMove=9, badMove=0.
REQ-032 sw=0 and sw=12, each pressed -> badMove=1, no strobe.
REQ-033 rawNewGame_L low during DEBOUNCE -> newGame_L low 2 edges later, no strobe, badMove=0; the held button yields no strobe until it is released and pressed again.
REQ-034 MOVE_ENTRY_DEBOUNCE_EN undefined, sw=4, press at edge 1 -> enter_L low after edge 3, hMove=4.
